// File: rtl/i281_display_scanner.sv
// Eight-digit multiplexed hex display for the i281 data memory: shows one 4-byte page.
// Memory is copied into a snapshot at each frame boundary. The page can be held or auto-rotated.
module i281_display_scanner #(
  parameter int REFRESH_DIV    = 50000,
  parameter int ROTATE_FRAMES  = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] datamem0,
  input  logic [7:0] datamem1,
  input  logic [7:0] datamem2,
  input  logic [7:0] datamem3,
  input  logic [7:0] datamem4,
  input  logic [7:0] datamem5,
  input  logic [7:0] datamem6,
  input  logic [7:0] datamem7,
  input  logic [7:0] datamem8,
  input  logic [7:0] datamem9,
  input  logic [7:0] datamem10,
  input  logic [7:0] datamem11,
  input  logic [7:0] datamem12,
  input  logic [7:0] datamem13,
  input  logic [7:0] datamem14,
  input  logic [7:0] datamem15,
  input  logic [1:0] page_sel,
  input  logic       auto_rotate,
  input  logic       freeze,
  output logic [6:0] seg,
  output logic       dp,
  output logic [7:0] digit_en,
  output logic [1:0] page_out,
  output logic       frame_tick
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FC_W  = (ROTATE_FRAMES > 1) ? $clog2(ROTATE_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(ROTATE_FRAMES - 1);
  localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW}};
  localparam logic [7:0] EN_POL  = {8{SEG_ACTIVE_LOW}};
  localparam logic       DP_POL  = SEG_ACTIVE_LOW;

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       digit_idx;
  logic [FC_W-1:0]  frame_cnt;
  logic [1:0]       page;
  logic [7:0]       live [16];
  logic [7:0]       snap [16];

  logic             div_last;
  logic             frame_end;
  logic [3:0]       byte_addr;
  logic [7:0]       cur_byte;
  logic [3:0]       nibble;
  logic [6:0]       seg_hi;
  logic [7:0]       en_hi;
  logic             dp_hi;

  always_comb begin
    live[0]  = datamem0;
    live[1]  = datamem1;
    live[2]  = datamem2;
    live[3]  = datamem3;
    live[4]  = datamem4;
    live[5]  = datamem5;
    live[6]  = datamem6;
    live[7]  = datamem7;
    live[8]  = datamem8;
    live[9]  = datamem9;
    live[10] = datamem10;
    live[11] = datamem11;
    live[12] = datamem12;
    live[13] = datamem13;
    live[14] = datamem14;
    live[15] = datamem15;
  end

  assign div_last  = (div_cnt == DIV_LAST);
  assign frame_end = div_last && (digit_idx == 3'd7);

  // Pair k = digit_idx[2:1] shows byte page*4 + (3-k); for two bits, 3-k is simply ~k.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    en_hi            = '0;
    en_hi[digit_idx] = 1'b1;
    byte_addr        = {page, ~digit_idx[2:1]};
    cur_byte         = snap[byte_addr];
    nibble           = digit_idx[0] ? cur_byte[7:4] : cur_byte[3:0];
    dp_hi            = (digit_idx == 3'd0) && freeze;
    case (nibble)
      4'h0:    seg_hi = 7'h3F;
      4'h1:    seg_hi = 7'h06;
      4'h2:    seg_hi = 7'h5B;
      4'h3:    seg_hi = 7'h4F;
      4'h4:    seg_hi = 7'h66;
      4'h5:    seg_hi = 7'h6D;
      4'h6:    seg_hi = 7'h7D;
      4'h7:    seg_hi = 7'h07;
      4'h8:    seg_hi = 7'h7F;
      4'h9:    seg_hi = 7'h6F;
      4'hA:    seg_hi = 7'h77;
      4'hB:    seg_hi = 7'h7C;
      4'hC:    seg_hi = 7'h39;
      4'hD:    seg_hi = 7'h5E;
      4'hE:    seg_hi = 7'h79;
      default: seg_hi = 7'h71;
    endcase
  end

  // Scan position and page selection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      div_cnt   <= '0;
      digit_idx <= '0;
      frame_cnt <= '0;
      page      <= '0;
    end else begin
      div_cnt <= div_last ? '0 : div_cnt + DIV_W'(1);
      if (div_last) begin
        digit_idx <= digit_idx + 3'd1;
      end
      if (!auto_rotate) begin
        frame_cnt <= '0;
        if (frame_end) begin
          page <= page_sel;
        end
      end else if (frame_end) begin
        if (frame_cnt == FC_LAST) begin
          frame_cnt <= '0;
          page      <= page + 2'd1;
        end else begin
          frame_cnt <= frame_cnt + FC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the snapshot is reset because a freshly reset display must show zeros, not stale RAM.
      for (int i = 0; i < 16; i++) begin
        snap[i] <= '0;
      end
    end else if (frame_end && !freeze) begin
      for (int i = 0; i < 16; i++) begin
        snap[i] <= live[i];
      end
    end
  end

  // Display pins are registered, so they trail the scan state by one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg        <= SEG_POL;
      dp         <= DP_POL;
      digit_en   <= EN_POL;
      page_out   <= '0;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_hi ^ SEG_POL;
      dp         <= dp_hi ^ DP_POL;
      digit_en   <= en_hi ^ EN_POL;
      page_out   <= page;
      frame_tick <= frame_end;
    end
  end

endmodule
